fp_div: RTL and testbench
=========================

# fp_div

Pipelined, parameterized IEEE-754 binary floating-point divider computing `result = a_operand / b_operand`. It accepts a new operand pair on every clock and returns the correctly rounded quotient a fixed two cycles later. It is the arithmetic datapath block used by the chaos-map iteration logic of the image-encryption core. The default configuration is single precision; double precision is obtained purely by parameters.

## Interface
- `PRECISION`, default 32: total word width.
- `EXPONENT`, default 8: exponent field width. Bias is 2^(EXPONENT-1)-1.
- `FRACTION`, default 23: stored fraction width. PRECISION = 1+EXPONENT+FRACTION. The 64/11/52 configuration must also work.
- `clk`, input, 1: single clock, rising-edge active.
- `reset_n`, input, 1: one clock; reset is asynchronous and active-high. The port keeps the codebase name `reset_n`, but reset is asserted when the signal is 1.
- `a_operand`, input, PRECISION: dividend, IEEE-754 format. Declared signed; treated as a raw bit pattern.
- `b_operand`, input, PRECISION: divisor, IEEE-754 format.
- `result`, output, PRECISION: quotient, IEEE-754 format, registered.

## Operation
- Sign: sign(a) XOR sign(b) for every finite and infinite result.
- Unpack: a biased exponent of 0 means zero. Denormal inputs are flushed to signed zero. A normal input gets a hidden leading 1 prepended to its fraction.
- Exponent: ea - eb + bias, computed with at least EXPONENT+2 bits, signed.
- Mantissa:
  - Divide by restoring or non-restoring long division of the (FRACTION+1)-bit significands.
  - Produce FRACTION+3 quotient bits plus a sticky bit (nonzero remainder).
  - Quotient lies in [0.5, 2). If it is below 1, shift left by 1 and decrement the exponent.
- Rounding: round to nearest, ties to even, using guard and sticky. If rounding carries out of the significand, renormalize and increment the exponent.
- Overflow: a final biased exponent ≥ 2^EXPONENT-1 gives signed infinity.
- Underflow: a final biased exponent ≤ 0 gives signed zero. No denormal outputs are produced.
- Special cases, checked in priority order:
  - Either input is NaN → canonical quiet NaN: sign 0, exponent all ones, fraction MSB 1 (0x7FC00000 for fp32).
  - 0/0 or inf/inf → canonical NaN.
  - inf/finite → signed infinity.
  - finite/inf → signed zero.
  - nonzero/0 → signed infinity.
  - 0/nonzero finite → signed zero.
- No exception flags, no handshake, no stall. Every cycle is a valid issue.

## Timing
- Two pipeline register stages:
  - Stage 1 registers the unpacked sign, exponent difference, significands and special-case code.
  - Stage 2 performs the division, normalization and rounding, and registers `result`.
- Latency: operands present before rising edge k appear on `result` after rising edge k+1, i.e. two edges after presentation. The exact visible edge is fixed by the two-register structure and must not vary with the data.
- Throughput: one operation per clock. Back-to-back distinct operands produce back-to-back distinct results, in order.
- Reset: while `reset_n`=1, all pipeline registers and `result` are cleared to 0, asynchronously. After deassertion, the first valid result appears two edges after the first sampled operands. Any data in flight when reset is asserted is discarded.
- Held inputs produce a stable `result` after the latency expires.

## Test plan
- Pipelined sign and round-up stream: apply one pair per cycle. Each result must appear exactly 2 cycles after its operands, in order.
  - 0x3F000000 / 0xBEE00000 → 0xBF924925.
  - 0xC0200000 / 0xBFC00000 → 0x3FD55555.
  - 0x40500000 / 0xBFC00000 → 0xC00AAAAB.
- Exact results: 0x41200000 / 0x3F000000 → 0x41A00000 (20.0). 0x3F800000 / 0x3F800000 → 0x3F800000.
- Specials: 0x3F800000 / 0x00000000 → 0x7F800000. 0x00000000 / 0x00000000 → 0x7FC00000. 0x7FC00000 / 0x3F800000 → 0x7FC00000. 0x3F800000 / 0xFF800000 → 0x80000000.
- Range: 0x7F000000 / 0x00800000 → 0x7F800000 (overflow). 0x00800000 / 0x7F000000 → 0x00000000 (underflow flush).
- Random compare: 10k random normal fp32 pairs against a reference model using round-to-nearest-even. Results must be bit-exact. Include 0x3E0A7EFA / 0xBF032F45 and 0x3AA3D70A / 0x3A449BA6 (≈1.6667).
- Reset: pulse `reset_n`=1 mid-stream. `result` must go to 0x00000000 immediately, without waiting for a clock edge. The first post-reset operands must appear 2 edges later.

Source files
------------

// File: rtl/fp_div.sv
// IEEE-754 divider (result = a_operand / b_operand), round-to-nearest-even, denormals flushed.
// Latency: two register stages; operands sampled at edge k are visible on result after edge k+1.
// Backpressure: none; a new operand pair is accepted every cycle and the pipeline never stalls.
module fp_div #(
  parameter int PRECISION = 32,
  parameter int EXPONENT  = 8,
  parameter int FRACTION  = 23
) (
  input  logic                        clk,
  input  logic                        reset_n,   // active-high despite the name
  input  logic signed [PRECISION-1:0] a_operand,
  input  logic        [PRECISION-1:0] b_operand,
  output logic        [PRECISION-1:0] result
);

  // Exponent arithmetic carries two extra bits so over/underflow stays visible as a signed value.
  localparam int EW = EXPONENT + 2;
  // Quotient bits: integer bit, FRACTION fraction bits, guard, round.
  localparam int QW = FRACTION + 3;

  localparam logic signed [EW-1:0] BIAS     = EW'((1 << (EXPONENT - 1)) - 1);
  localparam logic signed [EW-1:0] EXP_MAX  = EW'((1 << EXPONENT) - 1);
  localparam logic signed [EW-1:0] EXP_ONE  = EW'(1);
  localparam logic signed [EW-1:0] EXP_ZERO = EW'(0);

  localparam logic [PRECISION-1:0] QNAN =
    {1'b0, {EXPONENT{1'b1}}, 1'b1, {(FRACTION-1){1'b0}}};

  // Special-case code carried alongside the datapath. Zero encodes as 0 so a
  // cleared stage-1 register naturally produces +0.
  typedef enum logic [1:0] {
    SP_ZERO = 2'd0,
    SP_NONE = 2'd1,
    SP_INF  = 2'd2,
    SP_NAN  = 2'd3
  } special_t;

  typedef struct packed {
    logic              sign;
    special_t          special;
    logic [EW-1:0]     exp;      // signed exponent difference plus bias
    logic [FRACTION:0] ma;       // dividend significand with hidden bit
    logic [FRACTION:0] mb;       // divisor significand with hidden bit
  } stage1_t;

  // ---------------------------------------------------------------------------
  // Stage 1: unpack and classify
  // ---------------------------------------------------------------------------
  logic                a_sign, b_sign;
  logic [EXPONENT-1:0] a_exp, b_exp;
  logic [FRACTION-1:0] a_frac, b_frac;
  logic                a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;

  assign a_sign = a_operand[PRECISION-1];
  assign b_sign = b_operand[PRECISION-1];
  assign a_exp  = a_operand[PRECISION-2:FRACTION];
  assign b_exp  = b_operand[PRECISION-2:FRACTION];
  assign a_frac = a_operand[FRACTION-1:0];
  assign b_frac = b_operand[FRACTION-1:0];

  // A zero biased exponent covers both true zero and denormals, which are flushed.
  assign a_zero = (a_exp == '0);
  assign b_zero = (b_exp == '0);
  assign a_inf  = (&a_exp) && (a_frac == '0);
  assign b_inf  = (&b_exp) && (b_frac == '0);
  assign a_nan  = (&a_exp) && (a_frac != '0);
  assign b_nan  = (&b_exp) && (b_frac != '0);

  stage1_t s1_d, s1_q;

  // Classify the operand pair in priority order and form the biased exponent difference.
  always_comb begin
    s1_d      = '0;
    s1_d.sign = a_sign ^ b_sign;
    s1_d.exp  = $signed({2'b00, a_exp}) - $signed({2'b00, b_exp}) + BIAS;
    s1_d.ma   = {1'b1, a_frac};
    s1_d.mb   = {1'b1, b_frac};
    if (a_nan || b_nan)
      s1_d.special = SP_NAN;
    else if ((a_zero && b_zero) || (a_inf && b_inf))
      s1_d.special = SP_NAN;
    else if (a_inf)
      s1_d.special = SP_INF;
    else if (b_inf)
      s1_d.special = SP_ZERO;
    else if (b_zero)
      s1_d.special = SP_INF;
    else if (a_zero)
      s1_d.special = SP_ZERO;
    else
      s1_d.special = SP_NONE;
  end

  // Stage-1 pipeline register.
  always_ff @(posedge clk or posedge reset_n) begin
    if (reset_n)
      s1_q <= '0;
    else
      s1_q <= s1_d;
  end

  // ---------------------------------------------------------------------------
  // Stage 2: divide, normalize, round, pack
  // ---------------------------------------------------------------------------
  logic [FRACTION+1:0] rem;
  logic [QW-1:0]       quo;

  // Restoring long division: first step yields the integer bit, each later step one fraction bit.
  always_comb begin
    rem = {1'b0, s1_q.ma};
    quo = '0;
    for (int i = QW - 1; i >= 0; i--) begin
      if (rem >= {1'b0, s1_q.mb}) begin
        quo[i] = 1'b1;
        rem    = rem - {1'b0, s1_q.mb};
      end
      // After a restore the remainder is below mb, so its top bit is always clear here.
      rem = {rem[FRACTION:0], 1'b0};
    end
  end

  logic [FRACTION:0]   mant;
  logic                guard, sticky, round_up, carry;
  logic signed [EW-1:0] exp_n, exp_f;
  logic [FRACTION+1:0] mant_r;
  logic [FRACTION-1:0] frac_f;

  // Normalize the quotient into [1,2) and round to nearest even on guard/sticky.
  always_comb begin
    if (quo[QW-1]) begin
      mant   = quo[QW-1:2];
      guard  = quo[1];
      sticky = quo[0] | (|rem);
      exp_n  = $signed(s1_q.exp);
    end else begin
      // Quotient below one: the top quotient bit is zero, so the round bit becomes guard.
      mant   = quo[QW-2:1];
      guard  = quo[0];
      sticky = |rem;
      exp_n  = $signed(s1_q.exp) - EXP_ONE;
    end
    round_up = guard & (sticky | mant[0]);
    mant_r   = {1'b0, mant} + {{(FRACTION+1){1'b0}}, round_up};
    // Rounding 1.111..1 up carries to 10.000..0; renormalize by one position.
    carry    = mant_r[FRACTION+1];
    frac_f   = carry ? mant_r[FRACTION:1] : mant_r[FRACTION-1:0];
    exp_f    = carry ? (exp_n + EXP_ONE) : exp_n;
  end

  logic [PRECISION-1:0] result_d;

  // Select the packed result: specials first, then overflow/underflow clamping of the finite path.
  always_comb begin
    result_d = '0;
    case (s1_q.special)
      SP_NAN:  result_d = QNAN;
      SP_INF:  result_d = {s1_q.sign, {EXPONENT{1'b1}}, {FRACTION{1'b0}}};
      SP_ZERO: result_d = {s1_q.sign, {(PRECISION-1){1'b0}}};
      SP_NONE: begin
        if (exp_f >= EXP_MAX)
          result_d = {s1_q.sign, {EXPONENT{1'b1}}, {FRACTION{1'b0}}};
        else if (exp_f <= EXP_ZERO)
          result_d = {s1_q.sign, {(PRECISION-1){1'b0}}};
        else
          result_d = {s1_q.sign, exp_f[EXPONENT-1:0], frac_f};
      end
      default: result_d = '0;
    endcase
  end

  // Stage-2 output register.
  always_ff @(posedge clk or posedge reset_n) begin
    if (reset_n)
      result <= '0;
    else
      result <= result_d;
  end

endmodule

// File: tb/tb_fp_div.sv
// Bench for fp_div (fp32): directed pipelined stream, specials, range, reset and random vs a real-arithmetic model.
// Latency: each expectation is checked exactly two clock edges after its operands were applied.
// Backpressure: none; one operand pair is driven every cycle.
module tb_fp_div;

  logic               clk = 1'b0;
  logic               reset_n = 1'b0;
  logic signed [31:0] a_operand = '0;
  logic        [31:0] b_operand = '0;
  logic        [31:0] result;

  int total = 0;
  int bad   = 0;

  logic [31:0] pend_q[$];
  string       tag_q[$];

  logic [31:0] pool [8] = '{32'h00000000, 32'h80000000, 32'h7F800000, 32'hFF800000,
                            32'h7FC00000, 32'h7F800001, 32'h00000001, 32'h807FFFFF};

  always #5 clk = ~clk;

  fp_div #(.PRECISION(32), .EXPONENT(8), .FRACTION(23)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .a_operand(a_operand),
    .b_operand(b_operand),
    .result   (result)
  );

  // Reference: specials by rule, finite quotients via double division then RNE to 24 bits.
  function automatic logic [31:0] model(input logic [31:0] a, input logic [31:0] b);
    logic        s;
    logic [7:0]  ea, eb;
    logic [22:0] fa, fb;
    logic        an, bn, ai, bi, az, bz;
    real         ra, rb, q;
    logic [63:0] qb;
    logic [23:0] m;
    logic [24:0] mr;
    logic        g, st;
    int          e;
    s  = a[31] ^ b[31];
    ea = a[30:23]; eb = b[30:23];
    fa = a[22:0];  fb = b[22:0];
    an = (ea == 8'hFF) && (fa != 0);
    bn = (eb == 8'hFF) && (fb != 0);
    ai = (ea == 8'hFF) && (fa == 0);
    bi = (eb == 8'hFF) && (fb == 0);
    az = (ea == 0);
    bz = (eb == 0);
    if (an || bn) return 32'h7FC00000;
    if ((az && bz) || (ai && bi)) return 32'h7FC00000;
    if (ai) return {s, 8'hFF, 23'h0};
    if (bi) return {s, 31'h0};
    if (bz) return {s, 8'hFF, 23'h0};
    if (az) return {s, 31'h0};
    ra = $bitstoreal({1'b0, 11'(ea) + 11'd896, fa, 29'h0});
    rb = $bitstoreal({1'b0, 11'(eb) + 11'd896, fb, 29'h0});
    q  = ra / rb;
    qb = $realtobits(q);
    m  = {1'b1, qb[51:29]};
    g  = qb[28];
    st = |qb[27:0];
    mr = {1'b0, m} + {24'h0, (g & (st | m[0]))};
    e  = int'(qb[62:52]) - 1023 + 127;
    if (mr[24]) begin
      e++;
      mr = mr >> 1;
    end
    if (e >= 255) return {s, 8'hFF, 23'h0};
    if (e <= 0) return {s, 31'h0};
    return {s, 8'(e), mr[22:0]};
  endfunction

  function automatic logic [31:0] rnd_norm(input int lo, input int hi);
    logic [31:0] r;
    int          e;
    r = $urandom;
    e = $urandom_range(hi, lo);
    r[30:23] = 8'(e);
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] want);
    total++;
    assert (result === want) else begin
      bad++;
      $error("FAIL %s: result=%h expected=%h", tag, result, want);
    end
  endtask

  // Called #1 after a rising edge: check the pair issued two edges ago, drive a new pair, advance.
  task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic [31:0] want,
                       input string tag);
    string       t;
    logic [31:0] w;
    if (pend_q.size() == 2) begin
      t = tag_q.pop_front();
      w = pend_q.pop_front();
      chk(t, w);
    end
    a_operand = a;
    b_operand = b;
    pend_q.push_back(want);
    tag_q.push_back(tag);
    @(posedge clk);
    #1;
  endtask

  task automatic issue_rnd(input logic [31:0] a, input logic [31:0] b);
    issue(a, b, model(a, b), $sformatf("rnd %h/%h", a, b));
  endtask

  initial begin
    logic [31:0] ra, rb;
    int          mode;

    // Power-on reset: asserted between edges, output must clear without a clock.
    #1 reset_n = 1'b1;
    #1 chk("reset_async", 32'h0);
    @(posedge clk); @(posedge clk); #1;
    chk("reset_hold", 32'h0);
    reset_n = 1'b0;

    // Back-to-back directed stream: sign, round-up, exact results.
    issue(32'h3F000000, 32'hBEE00000, 32'hBF924925, "dir_0.5/-0.4375");
    issue(32'hC0200000, 32'hBFC00000, 32'h3FD55555, "dir_-2.5/-1.5");
    issue(32'h40500000, 32'hBFC00000, 32'hC00AAAAB, "dir_3.25/-1.5");
    issue(32'h41200000, 32'h3F000000, 32'h41A00000, "dir_10/0.5");
    issue(32'h3F800000, 32'h3F800000, 32'h3F800000, "dir_1/1");
    // Specials.
    issue(32'h3F800000, 32'h00000000, 32'h7F800000, "sp_1/0");
    issue(32'h00000000, 32'h00000000, 32'h7FC00000, "sp_0/0");
    issue(32'h7FC00000, 32'h3F800000, 32'h7FC00000, "sp_nan/1");
    issue(32'h3F800000, 32'hFF800000, 32'h80000000, "sp_1/-inf");
    issue(32'h7F800000, 32'h7F800000, 32'h7FC00000, "sp_inf/inf");
    issue(32'hFF800000, 32'h40000000, 32'hFF800000, "sp_-inf/2");
    issue(32'h80000000, 32'h40000000, 32'h80000000, "sp_-0/2");
    issue(32'h00400000, 32'h3F800000, 32'h00000000, "sp_denorm/1");
    // Range limits.
    issue(32'h7F000000, 32'h00800000, 32'h7F800000, "rng_overflow");
    issue(32'h00800000, 32'h7F000000, 32'h00000000, "rng_underflow");
    // Named random-compare operands.
    issue_rnd(32'h3E0A7EFA, 32'hBF032F45);
    issue_rnd(32'h3AA3D70A, 32'h3A449BA6);
    // Held inputs must keep producing the same result.
    repeat (4) issue(32'h40500000, 32'hBFC00000, 32'hC00AAAAB, "held");

    // Random stream, interrupted by an asynchronous reset pulse.
    for (int n = 0; n < 10000; n++) begin
      if (n == 5000) begin
        #2 reset_n = 1'b1;
        #1 chk("midrst_async", 32'h0);
        pend_q.delete();
        tag_q.delete();
        @(posedge clk); #1;
        chk("midrst_hold", 32'h0);
        reset_n = 1'b0;
        issue(32'h41200000, 32'h3F000000, 32'h41A00000, "post_rst_first");
        issue(32'hC0200000, 32'hBFC00000, 32'h3FD55555, "post_rst_second");
      end
      mode = $urandom_range(15, 0);
      if (mode == 0) begin
        ra = pool[$urandom_range(7, 0)];
        rb = rnd_norm(1, 254);
      end else if (mode == 1) begin
        ra = rnd_norm(1, 254);
        rb = pool[$urandom_range(7, 0)];
      end else if (mode < 6) begin
        ra = rnd_norm(1, 254);
        rb = rnd_norm(1, 254);
      end else begin
        ra = rnd_norm(110, 144);
        rb = rnd_norm(110, 144);
      end
      issue_rnd(ra, rb);
    end
    // Two trailing pairs push the last checked results out of the pipeline.
    issue_rnd(32'h3F800000, 32'h40000000);
    issue_rnd(32'h3F800000, 32'h40000000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
